// File: rtl/signed_divider.sv
// Multi-cycle signed restoring divider: quotient truncates toward zero, remainder follows dividend sign.
// Build option: define SIGNED_DIVIDER_REM_EN to compute the remainder output (otherwise it is tied to 0).
module signed_divider #(
   parameter int DW_A = 16,
   parameter int DW_B = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic signed [DW_A-1:0] dividend,
   input  logic signed [DW_B-1:0] divisor,
   output logic                   busy,
   output logic                   done,
   output logic signed [DW_A-1:0] quotient,
   output logic signed [DW_B-1:0] remainder,
   output logic                   dbz,
   output logic                   ovf
);

   localparam int CW = (DW_A > 1) ? $clog2(DW_A) : 1;
   localparam logic [DW_A-1:0] A_MIN = {1'b1, {(DW_A-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t r_state, w_next;

   logic signed [DW_A-1:0] r_a;
   logic signed [DW_B-1:0] r_b;
   logic [DW_A-1:0]        r_qm;
   logic [DW_B-1:0]        r_bm;
   logic [DW_B-1:0]        r_pr;
   logic                   r_sign;
   logic                   r_dbz_c;
   logic                   r_ovf_c;
   logic [DW_A-1:0]        r_qf;
   logic [CW-1:0]          r_cnt;
   logic                   r_done;
   logic [DW_A-1:0]        r_quot;
   logic                   r_dbz;
   logic                   r_ovf;

   logic [DW_B:0]          w_sh;
   logic                   w_ge;
   logic [DW_B-1:0]        w_diff;

   function automatic logic [DW_A-1:0] neg_a(input logic [DW_A-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [DW_B-1:0] neg_b(input logic [DW_B-1:0] x);
      return ~x + 1'b1;
   endfunction

   // DW_A-bit unsigned result keeps the most-negative value intact (0x8000 -> 0x8000).
   function automatic logic [DW_A-1:0] mag_a(input logic [DW_A-1:0] x);
      return x[DW_A-1] ? neg_a(x) : x;
   endfunction

   function automatic logic [DW_B-1:0] mag_b(input logic [DW_B-1:0] x);
      return x[DW_B-1] ? neg_b(x) : x;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = PREP;
         PREP:    w_next = CALC;
         CALC:    if (r_cnt == '0) w_next = FIX;
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Shift-subtract step: partial remainder is DW_B+1 bits only transiently, since it stays below the divisor.
   assign w_sh   = {r_pr, r_qm[DW_A-1]};
   assign w_ge   = (w_sh >= {1'b0, r_bm});
   assign w_diff = w_sh[DW_B-1:0] - r_bm;

`ifdef SIGNED_DIVIDER_REM_EN
   logic           r_nega;
   logic [DW_B-1:0] r_rf;
   logic [DW_B-1:0] r_rem;
`endif

   always_ff @(posedge clk) begin
      case (r_state)
         IDLE: begin
            if (start) begin
               r_a <= dividend;
               r_b <= divisor;
            end
         end
         PREP: begin
            r_qm    <= mag_a(r_a);
            r_bm    <= mag_b(r_b);
            r_pr    <= '0;
            r_sign  <= r_a[DW_A-1] ^ r_b[DW_B-1];
            r_dbz_c <= (r_b == '0);
            r_ovf_c <= (r_a == A_MIN) && (r_b == {DW_B{1'b1}});
`ifdef SIGNED_DIVIDER_REM_EN
            r_nega  <= r_a[DW_A-1];
`endif
         end
         CALC: begin
            r_pr <= w_ge ? w_diff : w_sh[DW_B-1:0];
            r_qm <= {r_qm[DW_A-2:0], w_ge};
         end
         FIX: begin
            r_qf <= r_dbz_c ? {DW_A{1'b1}} : (r_sign ? neg_a(r_qm) : r_qm);
`ifdef SIGNED_DIVIDER_REM_EN
            r_rf <= r_dbz_c ? '0 : (r_nega ? neg_b(r_pr) : r_pr);
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_quot <= '0;
         r_dbz  <= 1'b0;
         r_ovf  <= 1'b0;
`ifdef SIGNED_DIVIDER_REM_EN
         r_rem  <= '0;
`endif
      end else begin
         r_done <= (r_state == DONE);
         if (r_state == PREP)      r_cnt <= CW'(DW_A - 1);
         else if (r_state == CALC) r_cnt <= r_cnt - 1'b1;
         if (r_state == DONE) begin
            r_quot <= r_qf;
            r_dbz  <= r_dbz_c;
            r_ovf  <= r_ovf_c;
`ifdef SIGNED_DIVIDER_REM_EN
            r_rem  <= r_rf;
`endif
         end
      end
   end

   assign busy     = (r_state == PREP) || (r_state == CALC) || (r_state == FIX);
   assign done     = r_done;
   assign quotient = r_quot;
   assign dbz      = r_dbz;
   assign ovf      = r_ovf;
`ifdef SIGNED_DIVIDER_REM_EN
   assign remainder = r_rem;
`else
   assign remainder = '0;
`endif

endmodule

// File: tb/tb_signed_divider.sv
// Directed scoreboard bench for signed_divider: latency, sign combinations, error cases, busy-start, reset abort.
module tb_signed_divider;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [15:0] dividend;
   logic signed [7:0]  divisor;
   logic               busy;
   logic               done;
   logic signed [15:0] quotient;
   logic signed [7:0]  remainder;
   logic               dbz;
   logic               ovf;

   typedef struct packed {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      logic        ov;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   signed_divider #(.DW_A(16), .DW_B(8)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .dbz(dbz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rem_exp(input logic [7:0] r);
`ifdef SIGNED_DIVIDER_REM_EN
      return r;
`else
      return 8'h00 & r;
`endif
   endfunction

   // Drives one division, optionally pulsing start again mid-operation at cycle glitch_at.
   task automatic run_div(input logic signed [15:0] a, input logic signed [7:0] b,
                          input logic [15:0] q, input logic [7:0] r,
                          input logic dz, input logic ov, input string tag, input int glitch_at);
      exp_t e;
      int   n;
      e.q = q; e.r = rem_exp(r); e.dz = dz; e.ov = ov;
      sb.push_back(e);
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      check({tag, "_busy"}, {31'h0, busy}, 32'h1);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (n == glitch_at) begin
            start = 1'b1; dividend = 16'sd7; divisor = 8'sd2;
         end else begin
            start = 1'b0;
         end
      end
      check({tag, "_latency"}, n, 32'd19);
      if (sb.size() > 0) e = sb.pop_front();
      check({tag, "_q"},   {16'h0, quotient},  {16'h0, e.q});
      check({tag, "_r"},   {24'h0, remainder}, {24'h0, e.r});
      check({tag, "_dbz"}, {31'h0, dbz},       {31'h0, e.dz});
      check({tag, "_ovf"}, {31'h0, ovf},       {31'h0, e.ov});
      check({tag, "_busy_done"}, {31'h0, busy}, 32'h0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
      check({tag, "_q_hold"}, {16'h0, quotient}, {16'h0, e.q});
   endtask

   initial begin
      int n;
      int extra;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      check("rst_q",    {16'h0, quotient},  32'h0);
      check("rst_r",    {24'h0, remainder}, 32'h0);
      check("rst_busy", {31'h0, busy},      32'h0);
      check("rst_done", {31'h0, done},      32'h0);
      check("rst_flags", {30'h0, dbz, ovf}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run_div(16'sd100,    8'sd7,  16'sd14,   8'sd2,  1'b0, 1'b0, "p_p", 0);
      run_div(-16'sd100,   8'sd7,  -16'sd14,  -8'sd2, 1'b0, 1'b0, "n_p", 0);
      run_div(16'sd100,    -8'sd7, -16'sd14,  8'sd2,  1'b0, 1'b0, "p_n", 0);
      run_div(-16'sd100,   -8'sd7, 16'sd14,   -8'sd2, 1'b0, 1'b0, "n_n", 0);
      run_div(-16'sd32768, -8'sd1, 16'h8000,  8'sd0,  1'b0, 1'b1, "ovf", 0);
      run_div(-16'sd32768, 8'sd1,  16'h8000,  8'sd0,  1'b0, 1'b0, "min_1", 0);

      run_div(16'sd1000,   -8'sd13, -16'sd76, 8'sd12, 1'b0, 1'b0, "glitch", 5);
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("glitch_extra_done", extra, 32'd0);
      check("glitch_sb_empty", sb.size(), 32'd0);

      run_div(16'sd1234,   8'sd0,  16'hFFFF,  8'sd0,  1'b1, 1'b0, "dbz", 0);

      // Abort in the middle of CALC; outputs must clear at once and no result may appear.
      @(negedge clk);
      dividend = 16'sd100; divisor = 8'sd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 9) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      #1;
      check("abort_q",     {16'h0, quotient},  32'h0);
      check("abort_r",     {24'h0, remainder}, 32'h0);
      check("abort_flags", {30'h0, dbz, ovf},  32'h0);
      check("abort_busy",  {31'h0, busy},      32'h0);
      check("abort_done",  {31'h0, done},      32'h0);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("abort_no_done", extra, 32'd0);

      run_div(16'sd50, -8'sd3, -16'sd16, 8'sd2, 1'b0, 1'b0, "after_rst", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
